paddle_controller_multi: RTL and testbench

PADDLE_CONTROLLER_MULTI -- requirements
Module: paddle_controller_multi

---
 rtl/paddle_pkg.sv | 17 +
 rtl/paddle_channel.sv | 114 +++++++++++
 rtl/paddle_controller_multi.sv | 73 +++++++
 tb/tb_paddle_controller_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types and default geometry for the multi-player paddle controller.
package paddle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2
  } paddle_state_e;

  localparam int PADDLE_FIELD_H   = 600;
  localparam int PADDLE_BAT_SMALL = 60;
  localparam int PADDLE_BAT_LARGE = 120;

  // Width of the per-channel saturating hold counter.
  localparam int HOLD_W = 8;

endpackage

// File: rtl/paddle_channel.sv
// One paddle: IDLE/MOVE_UP/MOVE_DOWN FSM stepped on the shared tick, with
// hold-based acceleration, clamping to the playfield, and recentre support.
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int Y_W         = 11,
  parameter int FIELD_H     = PADDLE_FIELD_H,
  parameter int BAT_SMALL   = PADDLE_BAT_SMALL,
  parameter int BAT_LARGE   = PADDLE_BAT_LARGE,
  parameter int STEP_MIN    = 2,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           up,
  input  logic           down,
  input  logic           bat_size,
  input  logic           recenter,
  input  logic           freeze,
  output logic [Y_W-1:0] y_o,
  output logic           at_top_o,
  output logic           at_bottom_o,
  output logic [1:0]     state_o
);

  localparam int STEP_W = HOLD_W + 1;
  localparam logic [Y_W-1:0]    FIELD_H_W = Y_W'(FIELD_H);
  localparam logic [Y_W-1:0]    SMALL_W   = Y_W'(BAT_SMALL);
  localparam logic [Y_W-1:0]    LARGE_W   = Y_W'(BAT_LARGE);
  localparam logic [Y_W-1:0]    Y_RESET   = Y_W'((FIELD_H - BAT_LARGE) / 2);
  localparam logic [STEP_W-1:0] SMIN_W    = STEP_W'(STEP_MIN);
  localparam logic [STEP_W-1:0] SMAX_W    = STEP_W'(STEP_MAX);
  localparam logic [HOLD_W-1:0] ACCEL_W   = HOLD_W'(ACCEL_TICKS);

  paddle_state_e state_q, state_d, req_state;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [Y_W-1:0]    bat_len, y_max;
  logic [STEP_W-1:0] step_raw, step;
  logic signed [Y_W:0] y_ext, step_ext, y_calc, y_max_ext;

  always_comb begin
    bat_len   = bat_size ? LARGE_W : SMALL_W;
    y_max     = FIELD_H_W - bat_len;
    y_max_ext = signed'({1'b0, y_max});

    if (freeze || (up == down)) begin
      req_state = ST_IDLE;
    end else if (up) begin
      req_state = ST_MOVE_UP;
    end else begin
      req_state = ST_MOVE_DOWN;
    end

    state_d = state_q;
    hold_d  = hold_q;
    if (tick) begin
      state_d = req_state;
      // Hold counts consecutive ticks in one direction; any change restarts it.
      if ((req_state == ST_IDLE) || (req_state != state_q)) begin
        hold_d = '0;
      end else if (hold_q != '1) begin
        hold_d = hold_q + 1'b1;
      end
    end

    step_raw = SMIN_W + STEP_W'(hold_d / ACCEL_W);
    step     = (step_raw > SMAX_W) ? SMAX_W : step_raw;

    y_ext    = signed'({1'b0, y_q});
    step_ext = signed'((Y_W + 1)'(step));
    y_calc   = y_ext;
    if (tick && (state_d == ST_MOVE_UP)) begin
      y_calc = y_ext - step_ext;
    end else if (tick && (state_d == ST_MOVE_DOWN)) begin
      y_calc = y_ext + step_ext;
    end

    // Clamping runs every cycle so a bat-size change pulls y back in at once.
    if (y_calc[Y_W]) begin
      y_d = '0;
    end else if (y_calc > y_max_ext) begin
      y_d = y_max;
    end else begin
      y_d = y_calc[Y_W-1:0];
    end

    if (recenter) begin
      y_d     = y_max >> 1;
      state_d = ST_IDLE;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      y_q     <= Y_RESET;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
    end
  end

  assign y_o         = y_q;
  assign at_top_o    = (y_q == '0);
  assign at_bottom_o = (y_q == y_max);
  assign state_o     = state_q;

endmodule

// File: rtl/paddle_controller_multi.sv
// Multi-player paddle controller: shared movement tick divider plus one
// independent paddle_channel per player.
module paddle_controller_multi
  import paddle_pkg::*;
#(
  parameter int N_PLAYERS   = 2,
  parameter int Y_W         = 11,
  parameter int FIELD_H     = PADDLE_FIELD_H,
  parameter int BAT_SMALL   = PADDLE_BAT_SMALL,
  parameter int BAT_LARGE   = PADDLE_BAT_LARGE,
  parameter int TICK_DIV    = 250000,
  parameter int STEP_MIN    = 2,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PLAYERS-1:0]     up,
  input  logic [N_PLAYERS-1:0]     down,
  input  logic [N_PLAYERS-1:0]     bat_size,
  input  logic                     recenter,
  input  logic                     freeze,
  output logic [N_PLAYERS*Y_W-1:0] paddle_y,
  output logic [N_PLAYERS-1:0]     at_top,
  output logic [N_PLAYERS-1:0]     at_bottom,
  output logic [2*N_PLAYERS-1:0]   dbg_state
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  always_comb begin
    tick       = (tick_cnt_q == CNT_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_ch
    paddle_channel #(
      .Y_W        (Y_W),
      .FIELD_H    (FIELD_H),
      .BAT_SMALL  (BAT_SMALL),
      .BAT_LARGE  (BAT_LARGE),
      .STEP_MIN   (STEP_MIN),
      .STEP_MAX   (STEP_MAX),
      .ACCEL_TICKS(ACCEL_TICKS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .up         (up[i]),
      .down       (down[i]),
      .bat_size   (bat_size[i]),
      .recenter   (recenter),
      .freeze     (freeze),
      .y_o        (paddle_y[i*Y_W +: Y_W]),
      .at_top_o   (at_top[i]),
      .at_bottom_o(at_bottom[i]),
      .state_o    (dbg_state[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_paddle_controller_multi.sv
// Directed bench for paddle_controller_multi with TICK_DIV=4, two players.
module tb_paddle_controller_multi;
  import paddle_pkg::*;

  localparam int N   = 2;
  localparam int YW  = 11;
  localparam int DIV = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  up, down, bat_size;
  logic          recenter, freeze;
  logic [N*YW-1:0] paddle_y;
  logic [N-1:0]  at_top, at_bottom;
  logic [2*N-1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  paddle_controller_multi #(
    .N_PLAYERS(N),
    .Y_W      (YW),
    .TICK_DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .up       (up),
    .down     (down),
    .bat_size (bat_size),
    .recenter (recenter),
    .freeze   (freeze),
    .paddle_y (paddle_y),
    .at_top   (at_top),
    .at_bottom(at_bottom),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [YW-1:0] y0 = paddle_y[YW-1:0];
  wire [YW-1:0] y1 = paddle_y[2*YW-1:YW];
  wire [1:0]    st0 = dbg_state[1:0];
  wire [1:0]    st1 = dbg_state[3:2];

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    cycles(n * DIV);
  endtask

  task automatic clear_inputs();
    up = '0; down = '0; bat_size = 2'b11; recenter = 1'b0; freeze = 1'b0;
  endtask

  // Release lands on a negedge; the divider phase is 0 there.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
  endtask

  task automatic chk_y(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    cycles(1);
    chk_y("reset_y0", y0, 11'd240);
    chk_y("reset_y1", y1, 11'd240);
    checks++;
    if (at_top !== 2'b00 || at_bottom !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: top=%b bottom=%b expected 00/00", at_top, at_bottom);
    end
    checks++;
    if (dbg_state !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state: got %b expected 0000", dbg_state);
    end
    cycles(1);
    rst = 1'b1;
    up = 2'b01;
    cycles(3);
    chk_y("first_tick_not_early", y0, 11'd240);
    cycles(1);
    chk_y("first_tick_at_4", y0, 11'd238);
    up = '0;
  endtask

  task automatic test_up_clamp();
    clear_inputs();
    do_reset();
    up = 2'b01;
    ticks(16);
    chk_y("up_16", y0, 11'd208);
    ticks(16);
    chk_y("up_32", y0, 11'd160);
    ticks(8);
    chk_y("up_40", y0, 11'd128);
    checks++;
    if (at_top[0] !== 1'b0) begin
      failures++;
      $display("FAIL up_40_at_top: got %b expected 0", at_top[0]);
    end
    ticks(30);
    chk_y("up_clamp_0", y0, 11'd0);
    chk_y("up_p1_independent", y1, 11'd240);
    checks++;
    if (at_top !== 2'b01 || at_bottom !== 2'b00) begin
      failures++;
      $display("FAIL up_flags: top=%b bottom=%b expected 01/00", at_top, at_bottom);
    end
    up = '0;
  endtask

  task automatic test_bottom_bat();
    clear_inputs();
    do_reset();
    down = 2'b10;
    ticks(70);
    chk_y("down_clamp_480", y1, 11'd480);
    checks++;
    if (at_bottom[1] !== 1'b1) begin
      failures++;
      $display("FAIL down_at_bottom: got %b expected 1", at_bottom[1]);
    end
    down = '0;
    ticks(1);
    bat_size = 2'b01;
    cycles(1);
    chk_y("small_bat_y_stays", y1, 11'd480);
    checks++;
    if (at_bottom[1] !== 1'b0) begin
      failures++;
      $display("FAIL small_bat_at_bottom: got %b expected 0", at_bottom[1]);
    end
    cycles(3);
    down = 2'b10;
    ticks(30);
    chk_y("small_bat_clamp_540", y1, 11'd540);
    down = '0;
    ticks(1);
    bat_size = 2'b11;
    cycles(1);
    chk_y("grow_bat_clamp_480", y1, 11'd480);
    checks++;
    if (at_bottom[1] !== 1'b1) begin
      failures++;
      $display("FAIL grow_bat_at_bottom: got %b expected 1", at_bottom[1]);
    end
    cycles(3);
  endtask

  task automatic test_both_pressed();
    clear_inputs();
    do_reset();
    up = 2'b01;
    ticks(20);
    chk_y("both_pre", y0, 11'd196);
    down = 2'b01;
    ticks(3);
    chk_y("both_hold_y", y0, 11'd196);
    checks++;
    if (st0 !== ST_IDLE) begin
      failures++;
      $display("FAIL both_state: got %0d expected %0d", st0, ST_IDLE);
    end
    down = '0;
    ticks(1);
    chk_y("both_release_step2", y0, 11'd194);
    up = '0;
  endtask

  task automatic test_recenter();
    clear_inputs();
    do_reset();
    up = 2'b01;
    down = 2'b10;
    ticks(5);
    chk_y("pre_recenter_y0", y0, 11'd230);
    chk_y("pre_recenter_y1", y1, 11'd250);
    freeze = 1'b1;
    bat_size = 2'b00;
    cycles(3);
    recenter = 1'b1;
    cycles(1);
    recenter = 1'b0;
    chk_y("recenter_y0", y0, 11'd270);
    chk_y("recenter_y1", y1, 11'd270);
    checks++;
    if (st0 !== ST_IDLE || st1 !== ST_IDLE) begin
      failures++;
      $display("FAIL recenter_state: got %0d/%0d expected 0/0", st0, st1);
    end
    ticks(2);
    chk_y("freeze_y0", y0, 11'd270);
    chk_y("freeze_y1", y1, 11'd270);
    up = '0; down = '0; freeze = 1'b0;
  endtask

  task automatic test_reset_mid_move();
    clear_inputs();
    do_reset();
    down = 2'b01;
    ticks(21);
    chk_y("mid_pre_y", y0, 11'd287);
    checks++;
    if (st0 !== ST_MOVE_DOWN) begin
      failures++;
      $display("FAIL mid_pre_state: got %0d expected %0d", st0, ST_MOVE_DOWN);
    end
    cycles(2);
    #1 rst = 1'b0;
    #1;
    chk_y("mid_async_y", y0, 11'd240);
    checks++;
    if (st0 !== ST_IDLE) begin
      failures++;
      $display("FAIL mid_async_state: got %0d expected %0d", st0, ST_IDLE);
    end
    cycles(2);
    rst = 1'b1;
    cycles(3);
    chk_y("mid_no_early_move", y0, 11'd240);
    cycles(1);
    chk_y("mid_restart_step2", y0, 11'd242);
    down = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_up_clamp();
    test_bottom_bat();
    test_both_pressed();
    test_recenter();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
